// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate data cache (M-stage load/store in, ReadData/dhit out, line-refill/word-write memory handshake)
module dcache #(
  parameter int NLINES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         LoadM,
  input  logic         MemWriteM,
  input  logic         ByteM,
  input  logic [31:0]  ALUOutM,
  input  logic [31:0]  WriteDataM,
  output logic [31:0]  ReadData,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int IW = $clog2(NLINES);
  localparam int TW = 28 - IW;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [NLINES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [NLINES];
  logic [TW-1:0] tag_d [NLINES];
  logic [31:0] data_q [NLINES][4];
  logic [31:0] data_d [NLINES][4];
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0] mem_wstrb_q, mem_wstrb_d;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0] wsel;
  logic load, store, hit;
  logic [31:0] st_data;
  logic [3:0] st_strb;
  assign idx = ALUOutM[IW+3:4];
  assign tag = ALUOutM[31:IW+4];
  assign wsel = ALUOutM[3:2];
  assign store = MemWriteM;
  assign load = LoadM && !MemWriteM;
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign st_strb = ByteM ? 4'b1000 >> ALUOutM[1:0] : 4'hF;
  assign st_data = ByteM ? 32'({24'b0, WriteDataM[7:0]} << {~ALUOutM[1:0], 3'b0}) : WriteDataM;
  assign dhit = (state_q == IDLE) ? !(store || (load && !hit)) : (state_q == DONE);
  assign ReadData = (state_q == IDLE && load && hit) ? data_q[idx][wsel] : '0;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (store) begin
          state_d = WRITE;
          mem_req_d = 1'b1;
          mem_we_d = 1'b1;
          mem_addr_d = {ALUOutM[31:2], 2'b0};
          mem_wdata_d = st_data;
          mem_wstrb_d = st_strb;
        end else if (load && !hit) begin
          state_d = REFILL;
          mem_req_d = 1'b1;
          mem_we_d = 1'b0;
          mem_addr_d = {ALUOutM[31:4], 4'b0};
        end
      end
      REFILL, WRITE: begin
        if (mem_ready) begin
          if (state_q == REFILL) begin
            valid_d[idx] = 1'b1;
            tag_d[idx] = tag;
            for (int w = 0; w < 4; w++) data_d[idx][w] = mem_rdata[127-32*w -: 32];
          end else if (hit) begin
            for (int b = 0; b < 4; b++) if (st_strb[b]) data_d[idx][wsel][8*b +: 8] = st_data[8*b +: 8];
          end
          state_d = (state_q == REFILL) ? IDLE : DONE;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          mem_addr_d = '0;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized scoreboard bench for dcache against a word-level memory and tag-only cache model
module tb_dcache;
  localparam int NL = 4;
  localparam int IW = 2;
  logic clk = 0, reset = 1, LoadM = 0, MemWriteM = 0, ByteM = 0;
  logic [31:0] ALUOutM = 0, WriteDataM = 0;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic dhit, mem_req, mem_we;
  logic [3:0] mem_wstrb;
  logic [127:0] mem_rdata = 0;
  logic mem_ready = 0;
  always #5 clk = ~clk;
  dcache #(.NLINES(NL)) dut (
    .clk(clk), .reset(reset), .LoadM(LoadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadData(ReadData), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;} mreq_t;
  typedef struct {logic ld; logic [31:0] rd; int stalls;} ret_t;
  mreq_t mq[$];
  ret_t rq[$];
  int lat_q[$];
  int checks = 0, failures = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] phys_mem [int];
  logic rv [NL];
  logic [31:0] rtag [NL];
  logic manual = 0, mon_en = 0, abort = 0;
  function automatic logic [31:0] init_w(int k);
    return (k * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] ref_rd(int k);
    return ref_mem.exists(k) ? ref_mem[k] : init_w(k);
  endfunction
  function automatic logic [31:0] phys_rd(int k);
    return phys_mem.exists(k) ? phys_mem[k] : init_w(k);
  endfunction
  function automatic logic [31:0] mask(logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask
  // memory: latency per request comes from the stimulus side; stray ready pulses outside requests
  initial begin
    logic active;
    int wcnt, k;
    logic [31:0] w;
    active = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (manual) active = 0;
      else if (reset) begin
        active = 0;
        mem_ready = 0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1;
          wcnt = lat_q.size() != 0 ? lat_q.pop_front() : 1;
        end
        wcnt--;
        if (wcnt <= 0) begin
          active = 0;
          mem_ready = 1;
          if (mem_we) begin
            k = int'(mem_addr >> 2);
            w = phys_rd(k);
            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            phys_mem[k] = w;
          end else begin
            for (int i = 0; i < 4; i++) mem_rdata[127-32*i -: 32] = phys_rd(int'(mem_addr >> 2) + i);
          end
        end else mem_ready = 0;
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end
  // monitor: memory completions and access retirements against the scoreboard queues
  initial begin
    int stall;
    mreq_t m;
    ret_t r;
    stall = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) stall = 0;
      else begin
        if (mem_req && mem_ready) begin
          if (mq.size() == 0) flag("mem_unexpected_request");
          else begin
            m = mq.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) begin
              chk("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
              chk("mem_wdata", mem_wdata & mask(m.strb), m.wdata & mask(m.strb));
            end
          end
        end
        if (LoadM || MemWriteM) begin
          if (dhit) begin
            if (rq.size() == 0) flag("unexpected_retire");
            else begin
              r = rq.pop_front();
              chk("stall_cycles", 32'(stall), 32'(r.stalls));
              if (r.ld) chk("ReadData", ReadData, r.rd);
            end
            stall = 0;
          end else stall++;
        end
      end
    end
  end
  task automatic do_reset();
    reset = 1;
    mon_en = 0;
    LoadM = 0;
    MemWriteM = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < NL; i++) rv[i] = 0;
    mq.delete();
    rq.delete();
    lat_q.delete();
    mon_en = 1;
  endtask
  task automatic do_op(input logic ld, input logic st, input logic by, input logic [31:0] a,
                       input logic [31:0] wd, input int lat);
    int idx, k, lane;
    logic [31:0] tg, w;
    logic done;
    mreq_t m;
    ret_t r;
    if (abort) return;
    idx = int'((a >> 4) % NL);
    tg = a >> (4 + IW);
    k = int'(a >> 2);
    lane = 3 - int'(a % 4);
    r.ld = ld && !st;
    r.rd = 0;
    r.stalls = 0;
    if (st) begin
      w = ref_rd(k);
      m.we = 1;
      m.addr = k * 4;
      if (by) begin
        m.strb = 4'(1 << lane);
        m.wdata = 32'(wd[7:0]) << (8 * lane);
        w[8*lane +: 8] = wd[7:0];
      end else begin
        m.strb = 4'hF;
        m.wdata = wd;
        w = wd;
      end
      ref_mem[k] = w;
      mq.push_back(m);
      lat_q.push_back(lat);
      r.stalls = lat + 1;
    end else if (ld) begin
      r.rd = ref_rd(k);
      if (!(rv[idx] && rtag[idx] == tg)) begin
        rv[idx] = 1;
        rtag[idx] = tg;
        m.we = 0;
        m.addr = (a / 16) * 16;
        m.strb = 0;
        m.wdata = 0;
        mq.push_back(m);
        lat_q.push_back(lat);
        r.stalls = lat + 1;
      end
    end
    rq.push_back(r);
    LoadM = ld;
    MemWriteM = st;
    ByteM = by;
    ALUOutM = a;
    WriteDataM = wd;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      #3;
      done = dhit;
    end
    if (!done) begin
      flag("timeout_waiting_for_dhit");
      abort = 1;
    end
    @(posedge clk);
    #1;
    LoadM = 0;
    MemWriteM = 0;
  endtask
  task automatic do_idle();
    if (abort) return;
    LoadM = 0;
    MemWriteM = 0;
    ALUOutM = $urandom;
    @(negedge clk);
    #3;
    chk("idle_dhit", 32'(dhit), 1);
    chk("idle_ReadData", ReadData, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int sel;
    logic [31:0] a;
    do_reset();
    @(negedge clk);
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_dhit", 32'(dhit), 1);
    chk("rst_ReadData", ReadData, 0);
    @(posedge clk);
    #1;
    do_op(1, 0, 0, 32'h104, 0, 3);
    do_op(1, 0, 0, 32'h10C, 0, 1);
    do_op(0, 1, 0, 32'h108, 32'hDEADBEEF, 2);
    do_op(1, 0, 0, 32'h108, 0, 1);
    do_op(0, 1, 1, 32'h109, 32'h1234565A, 1);
    do_op(1, 0, 0, 32'h108, 0, 1);
    do_op(0, 1, 0, 32'h200, 32'hCAFEF00D, 2);
    do_op(1, 0, 0, 32'h200, 0, 2);
    do_op(1, 0, 0, 32'h000, 0, 1);
    do_op(1, 0, 0, 32'h040, 0, 2);
    do_op(1, 0, 0, 32'h000, 0, 1);
    do_op(0, 1, 0, 32'h300, 32'h11112222, 1);
    do_op(0, 1, 0, 32'h300, 32'h11112222, 1);
    do_op(1, 0, 0, 32'h300, 0, 1);
    do_idle();
    // reset lands in the same cycle as the refill completes
    manual = 1;
    mon_en = 0;
    mem_ready = 0;
    LoadM = 1;
    ALUOutM = 32'h340;
    @(negedge clk);
    #3;
    chk("midrst_detect_dhit", 32'(dhit), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #3;
    chk("midrst_mem_req", 32'(mem_req), 1);
    chk("midrst_mem_addr", mem_addr, 32'h340);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    mem_ready = 1;
    reset = 1;
    @(posedge clk);
    #1;
    mem_ready = 0;
    reset = 0;
    LoadM = 0;
    @(negedge clk);
    #3;
    chk("midrst_after_mem_req", 32'(mem_req), 0);
    chk("midrst_after_dhit", 32'(dhit), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) rv[i] = 0;
    mq.delete();
    rq.delete();
    lat_q.delete();
    manual = 0;
    mon_en = 1;
    do_op(1, 0, 0, 32'h340, 0, 2);
    do_op(1, 0, 0, 32'h300, 0, 1);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 19);
      a = 32'($urandom_range(0, 32'h3FF));
      if (sel == 0) do_idle();
      else if (sel == 1) do_op(1, 1, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(1, 4));
      else if (sel < 11) do_op(1, 0, 0, a, 0, $urandom_range(1, 4));
      else do_op(0, 1, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(1, 4));
    end
    repeat (3) do_idle();
    chk("mem_queue_drained", 32'(mq.size()), 0);
    chk("retire_queue_drained", 32'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache sitting between the memory stage of the pipelined datapath and main memory. It serves loads and stores addressed by `ALUOutM` and returns `ReadData`. It drives `dhit`, which the datapath uses as the global pipeline advance enable. Misses and stores stall the pipeline by holding `dhit` low while a line-refill or word-write handshake with memory completes.

## Interface
- `NLINES`, default 4: number of cache lines; power of 2, at least 2. Each line is 4 words (16 bytes).
- `clk` input, 1 bit: the single clock; everything updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `LoadM` input, 1 bit: memory-stage load (word or byte).
- `MemWriteM` input, 1 bit: memory-stage store.
- `ByteM` input, 1 bit: the store is a byte store. Word accesses ignore `ALUOutM[1:0]`.
- `ALUOutM` input, 32 bits: byte address.
- `WriteDataM` input, 32 bits: store data. For byte stores only bits [7:0] are used.
- `ReadData` output, 32 bits: the full word on a load hit, otherwise 0.
- `dhit` output, 1 bit: pipeline may advance this cycle.
- `mem_req` output, 1 bit: memory request, held high until `mem_ready`.
- `mem_we` output, 1 bit: 1 for a word write, 0 for a line read.
- `mem_addr` output, 32 bits: line address for a read (bits [3:0] = 0), word address for a write (bits [1:0] = 0).
- `mem_wdata` output, 32 bits: write word.
- `mem_wstrb` output, 4 bits: byte enables. Bit 3 is lane [31:24].
- `mem_rdata` input, 128 bits: refill line. Bits [127:96] are word 0.
- `mem_ready` input, 1 bit: request completes this cycle. Only meaningful while `mem_req` = 1.

## Operation
- **Address split:** offset = `ALUOutM[3:0]`, word = [3:2], index = [3+log2(NLINES):4], tag = the remaining upper bits.
- **Per-line state:** valid bit, tag, 4×32-bit data.
- **Hit:** the line at index is valid and its tag matches.
- **Byte lanes are big-endian:** `ALUOutM[1:0]` 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. A byte store places `WriteDataM[7:0]` in the selected lane and sets the matching `mem_wstrb` bit. A word store uses `mem_wstrb` = 4'b1111.
- **If `LoadM` and `MemWriteM` are both high,** treat the access as a store. This input combination is illegal upstream.

FSM states: IDLE, REFILL, WRITE, DONE.
- **IDLE**
  - No access: `dhit` = 1.
  - Load hit: `dhit` = 1, `ReadData` = hit word, stay in IDLE.
  - Load miss: `dhit` = 0, go to REFILL.
  - Store: `dhit` = 0, go to WRITE.
- **REFILL**
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {`ALUOutM`[31:4], 4'b0}; `dhit` = 0.
  - On `mem_ready`: write the line data, tag and valid = 1, replacing whatever was there; go to IDLE.
  - The load then hits in IDLE.
- **WRITE**
  - `mem_req` = 1, `mem_we` = 1, word-aligned `mem_addr`; `mem_wdata` and `mem_wstrb` as above; `dhit` = 0.
  - On `mem_ready`: if the access hits, merge the enabled bytes into the cached word; on a miss leave the cache unchanged (no allocate). Go to DONE.
- **DONE**
  - `dhit` = 1 for exactly one cycle, so the pipeline retires the store; then go to IDLE.
  - `mem_req` = 0.
- **Memory-side outputs:** `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered or derived from state plus stable M-stage inputs. They hold steady from request until `mem_ready`.
- **Stall stability:** the M-stage inputs stay stable while `dhit` = 0, because the pipeline is stalled.

## Timing
- **Reset values:** state IDLE, all valid bits 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0. `ReadData` is 0 and `dhit` is 1 when no access is presented.
- **Load hit:** 0 stall cycles. `ReadData` is combinational from the array in the same cycle.
- **Load miss:** 1 detect cycle in IDLE, then N REFILL cycles (N ≥ 1, ending with `mem_ready`), then the hit cycle. Total `dhit`-low cycles = N + 1.
- **Store:** 1 IDLE cycle, N WRITE cycles, then DONE with `dhit` = 1. Total `dhit`-low cycles = N + 1.
- **Reset mid-REFILL or mid-WRITE:** abort to IDLE on the next edge; `mem_req` = 0 from the next cycle. The line is not written, even if `mem_ready` arrives in the same cycle (reset wins). All valid bits are cleared.
- **`mem_ready` outside a request:** `mem_ready` while `mem_req` = 0 is ignored.
- **Back-to-back stores:** a store in DONE followed by a new store reaching M gets its own IDLE→WRITE sequence. No access is ever performed twice.

## Test plan
- **Cold load miss then hit:** reset, then load 0x00000104, memory answers after 3 cycles with line {A,B,C,D}. Required: `dhit` low for 4 cycles, `mem_addr` = 0x00000100, then `ReadData` = B. A repeat load of 0x10C hits immediately with `ReadData` = D.
- **Word store hit:** after that fill, store 0xDEADBEEF to 0x108. Required: `mem_we` = 1, `mem_wstrb` = 4'hF, DONE pulse. A subsequent load of 0x108 hits and returns 0xDEADBEEF.
- **Byte store lane:** byte store of 0x5A to 0x109. Required: `mem_wstrb` = 4'b0100 and `mem_wdata`[23:16] = 0x5A. A later load of 0x108 returns 0xDE5ABEEF.
- **Store miss, no allocate:** store to 0x200 with the cache cold. Required: the memory write occurs. A following load of 0x200 misses and refills.
- **Conflict eviction (NLINES = 4):** fill 0x000, then load 0x040 (same index, different tag). Required: a refill occurs and the old line is gone. Reloading 0x000 misses again.
- **Reset mid-refill:** assert reset during REFILL, in the same cycle as `mem_ready`. Required: next cycle state IDLE and `mem_req` = 0. Reloading the same address misses.
